// File: rtl/crc32_stream.sv
// Streaming CRC-32 engine: valid/ready beats of DATA_W bits, per-byte keep on
// the final beat, reflected or MSB-first bit order, registered result with a
// residue flag for FCS checking.
module crc32_stream #(
  parameter int          DATA_W  = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter bit          REFLECT = 1'b1,
  parameter logic [31:0] RESIDUE = 32'h2144DF1C
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W/8-1:0] keep_i,
  input  logic              last_i,
  output logic [31:0]       crc_o,
  output logic              crc_valid_o,
  output logic              crc_ok_o,
  output logic              busy_o
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic {RUN, TAIL} state_t;

  state_t            state_q, state_d;
  logic [31:0]       crc_q, crc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NB-1:0]     keep_q, keep_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       crc_out_d;
  logic              crc_valid_d, crc_ok_d, busy_d;
  logic              accept;
  logic [31:0]       base_crc, full_crc, tail_crc;

  // The register is always kept in normal (MSB-first) form; reflection only
  // changes which end of each byte is fed in first and the final reversal.
  function automatic logic [31:0] byte_update(input logic [31:0] c_in, input logic [7:0] byt);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ (REFLECT ? byt[i] : byt[7-i]);
      c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
    end
    return c;
  endfunction

  function automatic logic [31:0] beat_update(input logic [31:0] c_in, input logic [DATA_W-1:0] d);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < NB; b++) c = byte_update(c, d[8*b +: 8]);
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [31:0] finalise(input logic [31:0] c);
    return (REFLECT ? bitrev32(c) : c) ^ XOR_OUT;
  endfunction

  function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] i);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < NB; b++) if (i == IDX_W'(b)) r = d[8*b +: 8];
    return r;
  endfunction

  assign ready_o  = (state_q == RUN);
  assign accept   = valid_i & ready_o;
  assign base_crc = start_i ? INIT : crc_q;
  assign full_crc = beat_update(base_crc, data_i);
  assign tail_crc = keep_q[idx_q] ? byte_update(crc_q, get_byte(data_q, idx_q)) : crc_q;

  // Next-state and next-output decode; start_i wins and a same-cycle beat then runs from INIT.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    data_d      = data_q;
    keep_d      = keep_q;
    idx_d       = idx_q;
    crc_out_d   = crc_o;
    crc_ok_d    = crc_ok_o;
    crc_valid_d = 1'b0;
    busy_d      = busy_o;

    if (start_i) begin
      state_d = RUN;
      crc_d   = INIT;
      busy_d  = 1'b0;
    end

    if (accept) begin
      if (!last_i) begin
        crc_d  = full_crc;
        busy_d = 1'b1;
      end else if (&keep_i) begin
        crc_out_d   = finalise(full_crc);
        crc_ok_d    = (finalise(full_crc) == RESIDUE);
        crc_valid_d = 1'b1;
        crc_d       = INIT;
        busy_d      = 1'b0;
      end else begin
        crc_d   = base_crc;
        data_d  = data_i;
        keep_d  = keep_i;
        idx_d   = '0;
        state_d = TAIL;
        busy_d  = 1'b1;
      end
    end else if (!start_i && state_q == TAIL) begin
      if (idx_q == IDX_W'(NB - 1)) begin
        crc_out_d   = finalise(tail_crc);
        crc_ok_d    = (finalise(tail_crc) == RESIDUE);
        crc_valid_d = 1'b1;
        crc_d       = INIT;
        busy_d      = 1'b0;
        state_d     = RUN;
      end else begin
        crc_d = tail_crc;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // State and output registers, all returned to idle values by the async reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      crc_q       <= INIT;
      data_q      <= '0;
      keep_q      <= '0;
      idx_q       <= '0;
      crc_o       <= 32'h0;
      crc_valid_o <= 1'b0;
      crc_ok_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      idx_q       <= idx_d;
      crc_o       <= crc_out_d;
      crc_valid_o <= crc_valid_d;
      crc_ok_o    <= crc_ok_d;
      busy_o      <= busy_d;
    end
  end

endmodule

// File: tb/tb_crc32_stream.sv
// Scoreboard bench for crc32_stream: a 32-bit reflected instance and an 8-bit
// MSB-first instance, both checked against a byte-level CRC model.
module tb_crc32_stream;

  localparam logic [31:0] RES = 32'h2144DF1C;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [31:0] crc;
    logic        ok;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   tests = 0;
  int   fails = 0;

  // 32-bit reflected instance
  logic        start_i = 1'b0, valid_i = 1'b0, last_i = 1'b0;
  logic [31:0] data_i = '0;
  logic [3:0]  keep_i = '0;
  logic        ready, crc_valid, crc_ok, busy;
  logic [31:0] crc;

  // 8-bit MSB-first instance with no final XOR
  logic        s8_start = 1'b0, s8_valid = 1'b0, s8_last = 1'b0;
  logic [7:0]  s8_data = '0;
  logic [0:0]  s8_keep = '0;
  logic        r8_ready, r8_valid, r8_ok, r8_busy;
  logic [31:0] r8_crc;
  int          r8_low = 0;

  exp_t        sb32[$];
  exp_t        sb8[$];
  exp_t        e32, e8;
  logic [31:0] last_exp32 = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  crc32_stream dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .valid_i(valid_i), .ready_o(ready),
    .data_i(data_i), .keep_i(keep_i), .last_i(last_i), .crc_o(crc),
    .crc_valid_o(crc_valid), .crc_ok_o(crc_ok), .busy_o(busy)
  );

  crc32_stream #(.DATA_W(8), .REFLECT(1'b0), .XOR_OUT(32'h0)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(s8_start), .valid_i(s8_valid), .ready_o(r8_ready),
    .data_i(s8_data), .keep_i(s8_keep), .last_i(s8_last), .crc_o(r8_crc),
    .crc_valid_o(r8_valid), .crc_ok_o(r8_ok), .busy_o(r8_busy)
  );

  // Textbook byte-wise CRC-32: right-shifting table-free form when reflected.
  function automatic logic [31:0] model_crc(input bytes_t q, input bit refl, input logic [31:0] xo);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      if (refl) begin
        c = c ^ {24'h0, q[i]};
        repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end else begin
        c = c ^ {q[i], 24'h0};
        repeat (8) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
    end
    return c ^ xo;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor for the 32-bit instance: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && crc_valid) begin
      if (sb32.size() == 0) begin
        check_output("unexpected_pulse32", crc, 32'h0);
        check_output("unexpected_pulse32_flag", 32'h1, 32'h0);
      end else begin
        e32 = sb32.pop_front();
        last_exp32 = e32.crc;
        check_output("crc32", crc, e32.crc);
        check_output("crc_ok32", {31'b0, crc_ok}, {31'b0, e32.ok});
        check_output("latency32", 32'(cycle), 32'(e32.due));
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rst && r8_valid) begin
      if (sb8.size() == 0) begin
        check_output("unexpected_pulse8", 32'h1, 32'h0);
      end else begin
        e8 = sb8.pop_front();
        check_output("crc8", r8_crc, e8.crc);
        check_output("crc_ok8", {31'b0, r8_ok}, {31'b0, e8.ok});
        check_output("latency8", 32'(cycle), 32'(e8.due));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic apply_stimulus(input logic [31:0] d, input logic [3:0] k, input logic l,
                                input logic s, input bit push, input logic [31:0] ecrc);
    int g = 0;
    while (!ready && g < 20) begin @(negedge clk); g++; end
    if (!ready) check_output("ready_timeout32", 32'h0, 32'h1);
    if (push) sb32.push_back('{ecrc, ecrc == RES, cycle + 1 + ((l && k != 4'hF) ? 4 : 0)});
    data_i = d; keep_i = k; last_i = l; start_i = s; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; start_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic drive8(input logic [7:0] d, input logic k, input logic l,
                        input bit push, input logic [31:0] ecrc);
    int g = 0;
    while (!r8_ready && g < 20) begin r8_low++; @(negedge clk); g++; end
    if (!r8_ready) check_output("ready_timeout8", 32'h0, 32'h1);
    if (push) sb8.push_back('{ecrc, ecrc == RES, cycle + 1 + ((l && !k) ? 1 : 0)});
    s8_data = d; s8_keep = k; s8_last = l; s8_valid = 1'b1;
    @(negedge clk);
    s8_valid = 1'b0; s8_last = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((sb32.size() > 0 || sb8.size() > 0) && g < 100) begin @(negedge clk); g++; end
    check_output("drain32", 32'(sb32.size()), 32'h0);
    check_output("drain8", 32'(sb8.size()), 32'h0);
  endtask

  task automatic random_frame32();
    int          nbeats;
    bytes_t      bq;
    logic [31:0] d;
    logic [3:0]  k;
    nbeats = $urandom_range(1, 4);
    for (int b = 0; b < nbeats; b++) begin
      d = $urandom;
      if (b == nbeats - 1) begin
        k = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        for (int j = 0; j < 4; j++) if (k[j]) bq.push_back(d[8*j +: 8]);
        apply_stimulus(d, k, 1'b1, 1'b0, 1'b1, model_crc(bq, 1'b1, 32'hFFFFFFFF));
      end else begin
        for (int j = 0; j < 4; j++) bq.push_back(d[8*j +: 8]);
        apply_stimulus(d, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0, 32'h0);
      end
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic random_frame8();
    int         n;
    bytes_t     bq;
    logic [7:0] d;
    logic       k;
    n = $urandom_range(1, 6);
    for (int b = 0; b < n; b++) begin
      d = 8'($urandom_range(0, 255));
      if (b == n - 1) begin
        k = ($urandom_range(0, 3) != 0);
        if (k) bq.push_back(d);
        drive8(d, k, 1'b1, 1'b1, model_crc(bq, 1'b0, 32'h0));
      end else begin
        bq.push_back(d);
        drive8(d, 1'b1, 1'b0, 1'b0, 32'h0);
      end
    end
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  // Hard stop in case anything hangs.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bytes_t q;
    int     low;
    int     g;

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    check_output("rst_crc", crc, 32'h0);
    check_output("rst_flags", {28'h0, crc_valid, crc_ok, busy, ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // "123456789" with a one-byte tail
    apply_stimulus(32'h34333231, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h38373635, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h00000039, 4'b0001, 1'b1, 1'b0, 1'b1, 32'hCBF43926);
    check_output("tail_busy", {31'b0, busy}, 32'h1);
    low = 0; g = 0;
    while (!ready && g < 20) begin low++; @(negedge clk); g++; end
    check_output("tail_ready_low_cycles", 32'(low), 32'd4);
    drain();

    // Same payload followed by its FCS: residue expected
    apply_stimulus(32'h34333231, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h38373635, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'hF4392639, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h000000CB, 4'b0001, 1'b1, 1'b0, 1'b1, RES);
    drain();

    // Abort during a tail, then a clean frame
    apply_stimulus(32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'hCAFEF00D, 4'b0011, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check_output("abort_busy_ready", {30'h0, busy, ready}, 32'h1);
    apply_stimulus(32'h34333231, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h38373635, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h00000039, 4'b0001, 1'b1, 1'b0, 1'b1, 32'hCBF43926);
    drain();

    // start_i together with an accepted beat restarts from INIT using that beat
    apply_stimulus(32'h11223344, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h34333231, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0);
    check_output("start_beat_busy", {31'b0, busy}, 32'h1);
    apply_stimulus(32'h38373635, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h00000039, 4'b0001, 1'b1, 1'b0, 1'b1, 32'hCBF43926);
    drain();

    // Back-to-back full-keep frames with no idle cycle
    q = '{8'h31, 8'h32, 8'h33, 8'h34};
    apply_stimulus(32'h34333231, 4'hF, 1'b1, 1'b0, 1'b1, model_crc(q, 1'b1, 32'hFFFFFFFF));
    q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    apply_stimulus(32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 1'b1, model_crc(q, 1'b1, 32'hFFFFFFFF));
    q = '{8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
    apply_stimulus(32'h38373635, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 1'b1, model_crc(q, 1'b1, 32'hFFFFFFFF));
    drain();

    // keep_i = 0 on the last beat: only the earlier bytes count
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    apply_stimulus(32'h34333231, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h38373635, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'hA5A5A5A5, 4'b0000, 1'b1, 1'b0, 1'b1, model_crc(q, 1'b1, 32'hFFFFFFFF));
    drain();

    // Result holds while idle
    repeat (3) @(negedge clk);
    check_output("hold_crc", crc, last_exp32);
    check_output("hold_no_pulse", {31'b0, crc_valid}, 32'h0);

    // Randomized frames
    for (int f = 0; f < 40; f++) random_frame32();
    drain();

    // Reset in the middle of a tail clears everything immediately
    apply_stimulus(32'h12345678, 4'b0101, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("midtail_rst_crc", crc, 32'h0);
    check_output("midtail_rst_flags", {28'h0, crc_valid, crc_ok, busy, ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    apply_stimulus(32'h34333231, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h38373635, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h00000039, 4'b0001, 1'b1, 1'b0, 1'b1, 32'hCBF43926);
    drain();

    // 8-bit MSB-first instance, XOR_OUT = 0: "123456789" one byte per beat
    r8_low = 0;
    for (int i = 1; i <= 9; i++)
      drive8(8'h30 + 8'(i), 1'b1, (i == 9), (i == 9), 32'h0376E6E7);
    check_output("ready8_never_low", 32'(r8_low), 32'h0);
    drain();
    for (int f = 0; f < 20; f++) random_frame8();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crc32_stream.md
Name: crc32_stream

Overview:
- Streaming CRC-32 engine that accepts DATA_W-bit beats over a valid/ready handshake.
- Handles partial final beats via per-byte keep, and supports reflected or non-reflected bit order.
- Delivers a registered CRC result, plus a residue check for FCS verification, for packet TX/RX paths.
- Successor to the fixed 16-bit combinational CRC-32 step: adds configurable width, configurable init/xor/reflection, framing and tail sequencing.

Parameters:
- DATA_W, 32, beat width in bits; multiple of 8, range 8..64; NB = DATA_W/8.
- POLY, 32'h04C11DB7, generator polynomial, normal form.
- INIT, 32'hFFFFFFFF, register value at frame start.
- XOR_OUT, 32'hFFFFFFFF, final XOR applied to the result.
- REFLECT, 1, 1 = each byte processed LSB first and result bit-reversed before XOR_OUT; 0 = MSB first, left shift, no reversal.
- RESIDUE, 32'h2144DF1C, crc_o value signalling a good frame that includes its FCS.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active high.
- start_i  in  1  abort current frame; reload INIT.
- valid_i  in  1  beat valid.
- ready_o  out  1  engine can accept a beat.
- data_i  in  DATA_W  beat data; byte b = data_i[8b+7:8b]; byte 0 processed first.
- keep_i  in  NB  byte enables; only sampled on last beats.
- last_i  in  1  final beat of frame.
- crc_o  out  32  result of most recent completed frame.
- crc_valid_o  out  1  one-cycle pulse when crc_o updates.
- crc_ok_o  out  1  (crc_o == RESIDUE), registered with crc_o.
- busy_o  out  1  frame in progress (≥1 beat accepted, not yet completed).

Behaviour:
- Reset (async): state=RUN, crc register=INIT, crc_o=0, crc_valid_o=0, crc_ok_o=0, busy_o=0, ready_o=1.
- Accept = valid_i & ready_o at rising edge.

States: RUN, TAIL.

RUN (ready_o=1):
- Accept, last_i=0: register <= NB-byte update of register with all bytes (keep ignored), single cycle. busy_o=1.
- Accept, last_i=1, keep_i all ones: full update.
  - crc_o <= finalise(updated), where finalise = (REFLECT ? bitrev32 : id) ^ XOR_OUT.
  - crc_ok_o <= (finalise(updated) == RESIDUE); crc_valid_o=1 next cycle.
  - register <= INIT; busy_o <= 0.
- Accept, last_i=1, keep_i not all ones: latch data and keep, idx <= 0, go TAIL.

TAIL (ready_o=0, busy_o=1):
- One cycle per byte index idx = 0..NB-1.
- Update register with byte idx only if keep[idx]=1, otherwise hold.
- After idx = NB-1: finalise as above, crc_valid_o pulses next cycle, register <= INIT, go RUN.
- Fixed latency: result visible NB+1 cycles after the partial last beat is accepted, regardless of keep pattern.
- Non-contiguous keep: cleared bytes are skipped; remaining bytes processed in ascending order.
- keep_i = 0: no bytes processed; result = finalise(register).

start_i (any state, highest priority):
- register <= INIT, go RUN, busy_o <= 0; any TAIL in progress is discarded, with no crc_valid_o pulse.
- A beat accepted in the same cycle as start_i is processed against INIT, in RUN only.

Other rules:
- crc_o and crc_ok_o hold between frames.
- crc_valid_o is never high for two consecutive cycles except for back-to-back full-keep last beats.
- Back-to-back frames with no idle cycle are supported; each new frame starts from INIT.
- Reset mid-TAIL: all state returns to reset values; no pulse.

Test Plan:
- DATA_W=32, REFLECT=1: beats 32'h34333231, 32'h38373635, 32'h00000039 with keep 4'b0001 and last -> ready_o low 4 cycles; crc_o=32'hCBF43926 with crc_valid_o 5 cycles after the last beat; crc_ok_o=0.
- Same config: 13 bytes "123456789"+FCS, i.e. 32'h34333231, 32'h38373635, 32'hF4392639, then 32'h000000CB keep 4'b0001 last -> crc_o=32'h2144DF1C, crc_ok_o=1.
- REFLECT=0, XOR_OUT=32'hFFFFFFFF: "123456789" -> crc_o=32'hFC891918. REFLECT=0, XOR_OUT=0: crc_o=32'h0376E6E7.
- DATA_W=8, REFLECT=1: 9 single-byte beats '1'..'9', last on the 9th with keep 1'b1 -> crc_o=32'hCBF43926, one cycle after acceptance; ready_o never deasserts.
- Abort and reset:
  - start_i during TAIL of a frame, then a full "123456789" frame -> exactly one crc_valid_o, crc_o=32'hCBF43926.
  - rst_i asserted mid-frame -> all outputs 0 and ready_o=1 asynchronously.
- Back-to-back: two frames, each ending in a full-keep last beat, no idle cycle between them -> two consecutive crc_valid_o pulses, each crc_o correct; keep_i=0 last beat -> crc_o = finalise of the preceding bytes.
